// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operand-select path: source selects, opcodes,
// fault codes and the operand controller state enum.
package alu_ctrl_pkg;

  localparam logic [2:0] SRC_ZERO    = 3'b000;
  localparam logic [2:0] SRC_PC4     = 3'b001;
  localparam logic [2:0] SRC_PC      = 3'b010;
  localparam logic [2:0] SRC_REG     = 3'b011;
  localparam logic [2:0] SRC_IMM12   = 3'b100;
  localparam logic [2:0] SRC_IMM20U  = 3'b101;
  localparam logic [2:0] SRC_XMM     = 3'b110;
  localparam logic [2:0] SRC_IMM12HL = 3'b111;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_XMM_DEF = 7'b0001011;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XREQ  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_src_decode.sv
// Opcode to ALU port A/B source selects, plus XMM and illegal-opcode flags.
// Purely combinational; no handshake.
module alu_src_decode
  import alu_ctrl_pkg::*;
#(
  parameter logic [6:0] XMM_OPCODE = OPC_XMM_DEF
) (
  input  logic [6:0] opcode_i,
  output logic [2:0] a_src_o,
  output logic [2:0] b_src_o,
  output logic       is_xmm_o,
  output logic       illegal_o
);

  always_comb begin
    a_src_o   = SRC_ZERO;
    b_src_o   = SRC_ZERO;
    is_xmm_o  = 1'b0;
    illegal_o = 1'b0;
    // XMM is checked first so a custom opcode can never alias a base one.
    if (opcode_i == XMM_OPCODE) begin
      a_src_o  = SRC_XMM;
      b_src_o  = SRC_REG;
      is_xmm_o = 1'b1;
    end else begin
      case (opcode_i)
        OPC_LUI:               begin a_src_o = SRC_ZERO; b_src_o = SRC_IMM20U;  end
        OPC_AUIPC:             begin a_src_o = SRC_PC;   b_src_o = SRC_IMM20U;  end
        OPC_JAL, OPC_JALR:     begin a_src_o = SRC_PC4;  b_src_o = SRC_ZERO;    end
        OPC_OP_IMM, OPC_LOAD:  begin a_src_o = SRC_REG;  b_src_o = SRC_IMM12;   end
        OPC_OP, OPC_BRANCH:    begin a_src_o = SRC_REG;  b_src_o = SRC_REG;     end
        OPC_STORE:             begin a_src_o = SRC_REG;  b_src_o = SRC_IMM12HL; end
        default:               illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Per-instruction ALU operand-select sequencer with optional XMM read phase.
// Issue 1 cycle after accept (or after xs_rd_ack); selects held until alu_op_ready.
module alu_operand_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [6:0]  XMM_OPCODE = 7'b0001011,
  parameter int unsigned XS_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        xs_rd_req,
  input  logic        xs_rd_ack,
  output logic [2:0]  alu_a_src,
  output logic [2:0]  alu_b_src,
  output logic        alu_op_valid,
  input  logic        alu_op_ready,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [7:0] CNT_LAST = 8'(XS_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [1:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;

  logic [2:0] dec_a, dec_b;
  logic       dec_xmm, dec_illegal;

  // Only the opcode steers operand selection; the rest of the word is not needed here.
  logic unused_instr;
  assign unused_instr = ^instr[31:7];

  alu_src_decode #(
    .XMM_OPCODE (XMM_OPCODE)
  ) u_decode (
    .opcode_i  (instr[6:0]),
    .a_src_o   (dec_a),
    .b_src_o   (dec_b),
    .is_xmm_o  (dec_xmm),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= SRC_ZERO;
      b_q     <= SRC_ZERO;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    instr_ready  = 1'b0;
    xs_rd_req    = 1'b0;
    alu_op_valid = 1'b0;
    fault        = 1'b0;
    fault_code   = FC_NONE;
    alu_a_src    = SRC_ZERO;
    alu_b_src    = SRC_ZERO;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          a_d     = dec_a;
          b_d     = dec_b;
          code_d  = dec_illegal ? FC_ILLEGAL : FC_NONE;
          cnt_d   = '0;
          state_d = dec_xmm ? ST_XREQ : ST_ISSUE;
        end
      end
      ST_XREQ: begin
        // An ack in the final wait cycle still beats the timeout.
        if (xs_rd_ack) begin
          code_d  = FC_NONE;
          state_d = ST_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = FC_TIMEOUT;
          a_d     = SRC_ZERO;
          b_d     = SRC_ZERO;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (alu_op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow registered state; reset forces them all low.
    if (!reset) begin
      case (state_q)
        ST_IDLE:  instr_ready = 1'b1;
        ST_XREQ:  xs_rd_req   = 1'b1;
        ST_ISSUE: begin
          alu_op_valid = 1'b1;
          fault        = (code_q != FC_NONE);
          fault_code   = code_q;
          alu_a_src    = a_q;
          alu_b_src    = b_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl with hand-computed expected outputs.
module tb_alu_operand_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        xs_rd_req;
  logic        xs_rd_ack;
  logic [2:0]  alu_a_src;
  logic [2:0]  alu_b_src;
  logic        alu_op_valid;
  logic        alu_op_ready;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  alu_operand_ctrl #(
    .XMM_OPCODE (7'b0001011),
    .XS_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .xs_rd_req    (xs_rd_req),
    .xs_rd_ack    (xs_rd_ack),
    .alu_a_src    (alu_a_src),
    .alu_b_src    (alu_b_src),
    .alu_op_valid (alu_op_valid),
    .alu_op_ready (alu_op_ready),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (ir,rq,v,f,fc[2],a[3],b[3])", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ir, input logic rq, input logic v,
                            input logic f, input logic [1:0] fc, input logic [2:0] a,
                            input logic [2:0] b);
    chk(tag, {instr_ready, xs_rd_req, alu_op_valid, fault, fault_code, alu_a_src, alu_b_src},
        {ir, rq, v, f, fc, a, b});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    instr_valid  = 1'b0;
    instr        = 32'h0;
    xs_rd_ack    = 1'b0;
    alu_op_ready = 1'b0;
    step();
    step();
    expect_out("reset_held", 0, 0, 0, 0, 2'b00, 3'b000, 3'b000);
    reset = 1'b0;
    step();
    expect_out("idle_after_reset", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    // Stray ack in IDLE has no effect.
    xs_rd_ack = 1'b1;
    step();
    xs_rd_ack = 1'b0;
    expect_out("stray_ack", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    // ADDI with consumer ready.
    instr_valid = 1'b1; instr = 32'h00510093; alu_op_ready = 1'b1;
    step();
    instr_valid = 1'b0;
    expect_out("addi_issue", 0, 0, 1, 0, 2'b00, 3'b011, 3'b100);
    step();
    expect_out("addi_done", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    // LUI held four cycles, SW offered during release cycle must wait.
    instr_valid = 1'b1; instr = 32'h12345037; alu_op_ready = 1'b0;
    step();
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("lui_hold%0d", i), 0, 0, 1, 0, 2'b00, 3'b000, 3'b101);
      if (i == 3) begin
        alu_op_ready = 1'b1;
        instr_valid  = 1'b1;
        instr        = 32'h00112223;
      end
      step();
    end
    expect_out("sw_wait_idle", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);
    step();
    instr_valid = 1'b0;
    expect_out("sw_issue", 0, 0, 1, 0, 2'b00, 3'b011, 3'b111);
    step();

    // XMM with ack on the third XREQ cycle.
    instr_valid = 1'b1; instr = 32'h0000000B;
    step();
    instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      expect_out($sformatf("xmm_req%0d", k), 0, 1, 0, 0, 2'b00, 3'b000, 3'b000);
      if (k == 3) xs_rd_ack = 1'b1;
      step();
    end
    xs_rd_ack = 1'b0;
    expect_out("xmm_issue", 0, 0, 1, 0, 2'b00, 3'b110, 3'b011);
    step();
    expect_out("xmm_done", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    // XMM timeout: request high exactly 15 cycles.
    instr_valid = 1'b1; instr = 32'h0000000B;
    step();
    instr_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      expect_out($sformatf("to_req%0d", k), 0, 1, 0, 0, 2'b00, 3'b000, 3'b000);
      step();
    end
    expect_out("to_issue", 0, 0, 1, 1, 2'b10, 3'b000, 3'b000);
    step();

    // Ack in the 15th cycle wins over the timeout.
    instr_valid = 1'b1; instr = 32'h0000000B;
    step();
    instr_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 1 || k == 15)
        expect_out($sformatf("late_req%0d", k), 0, 1, 0, 0, 2'b00, 3'b000, 3'b000);
      if (k == 15) xs_rd_ack = 1'b1;
      step();
    end
    xs_rd_ack = 1'b0;
    expect_out("late_ack_issue", 0, 0, 1, 0, 2'b00, 3'b110, 3'b011);
    step();

    // Illegal opcode.
    instr_valid = 1'b1; instr = 32'h0000007F;
    step();
    instr_valid = 1'b0;
    expect_out("illegal_issue", 0, 0, 1, 1, 2'b01, 3'b000, 3'b000);
    step();
    expect_out("illegal_done", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    // Reset during XREQ cycle 2, then normal ADDI.
    instr_valid = 1'b1; instr = 32'h0000000B;
    step();
    instr_valid = 1'b0;
    expect_out("rst_xreq1", 0, 1, 0, 0, 2'b00, 3'b000, 3'b000);
    step();
    reset = 1'b1;
    step();
    expect_out("rst_mid_xreq", 0, 0, 0, 0, 2'b00, 3'b000, 3'b000);
    reset = 1'b0;
    step();
    expect_out("rst_recover_idle", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);
    instr_valid = 1'b1; instr = 32'h00510093;
    step();
    instr_valid = 1'b0;
    expect_out("rst_addi_issue", 0, 0, 1, 0, 2'b00, 3'b011, 3'b100);
    step();
    expect_out("rst_addi_done", 1, 0, 0, 0, 2'b00, 3'b000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
